// File: rtl/mvau_out_packer_pkg.sv
// mvau_out_packer_pkg: default geometry and element type shared by the output packer
package mvau_out_packer_pkg;
  localparam int PE_DEF = 4;
  localparam int SIMD_OUT_DEF = 2;
  localparam int TDSTI_DEF = 8;
  localparam int MATRIXH_DEF = 8;
  localparam int BUF_ELEMS_DEF = 16;
  typedef logic [TDSTI_DEF-1:0] elem_t;
endpackage

// File: rtl/mvau_pack_ringbuf.sv
// mvau_pack_ringbuf: element ring buffer with PE-wide write and SIMD_OUT-wide read
module mvau_pack_ringbuf import mvau_out_packer_pkg::*; #(
  parameter int PE = PE_DEF,
  parameter int SIMD_OUT = SIMD_OUT_DEF,
  parameter int TDSTI = TDSTI_DEF,
  parameter int BUF_ELEMS = BUF_ELEMS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [PE*TDSTI-1:0]       wr_data,
  output logic [SIMD_OUT*TDSTI-1:0] rd_data
);
  localparam int AW = $clog2(BUF_ELEMS);
  logic [TDSTI-1:0] mem [BUF_ELEMS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= (int'(wr_ptr) + PE == BUF_ELEMS) ? '0 : wr_ptr + AW'(PE);
      if (rd_en) rd_ptr <= (int'(rd_ptr) + SIMD_OUT == BUF_ELEMS) ? '0 : rd_ptr + AW'(SIMD_OUT);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) for (int i = 0; i < PE; i++) mem[wr_ptr + AW'(i)] <= wr_data[i*TDSTI +: TDSTI];
  end
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < SIMD_OUT; j++) rd_data[j*TDSTI +: TDSTI] = mem[rd_ptr + AW'(j)];
  end
endmodule

// File: rtl/mvau_out_packer.sv
// mvau_out_packer: repacks PE-lane MVAU result beats into SIMD_OUT-lane beats with vector framing
module mvau_out_packer import mvau_out_packer_pkg::*; #(
  parameter int PE = PE_DEF,
  parameter int SIMD_OUT = SIMD_OUT_DEF,
  parameter int TDSTI = TDSTI_DEF,
  parameter int MATRIXH = MATRIXH_DEF,
  parameter int BUF_ELEMS = BUF_ELEMS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PE*TDSTI-1:0]       in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SIMD_OUT*TDSTI-1:0] out_data,
  output logic                      out_last
);
  localparam int CW = $clog2(BUF_ELEMS + 1);
  localparam int BEATS = MATRIXH / SIMD_OUT;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [CW-1:0] count;
  logic [BW-1:0] beat;
  logic in_fire, out_fire;
  logic [SIMD_OUT*TDSTI-1:0] rd_data;
  assign in_ready = int'(count) <= BUF_ELEMS - PE;
  assign out_valid = int'(count) >= SIMD_OUT;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_last = out_valid & (int'(beat) == BEATS - 1);
  assign out_data = out_valid ? rd_data : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      beat <= '0;
    end else begin
      count <= count + (in_fire ? CW'(PE) : '0) - (out_fire ? CW'(SIMD_OUT) : '0);
      if (out_fire) beat <= (int'(beat) == BEATS - 1) ? '0 : beat + BW'(1);
    end
  end
  mvau_pack_ringbuf #(.PE(PE), .SIMD_OUT(SIMD_OUT), .TDSTI(TDSTI), .BUF_ELEMS(BUF_ELEMS)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(in_fire),
    .rd_en(out_fire),
    .wr_data(in_data),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_mvau_out_packer.sv
// tb_mvau_out_packer: directed table plus hand sequences for the output packer
module tb_mvau_out_packer;
  import mvau_out_packer_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [31:0] in_data = '0;
  logic out_valid;
  logic out_ready = 0;
  logic [15:0] out_data;
  logic out_last;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic iv;
    logic [31:0] d;
    logic ordy;
    logic e_ir;
    logic e_ov;
    logic [15:0] e_d;
    logic e_l;
  } vec_t;
  vec_t tbl [20];
  mvau_out_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy);
    @(negedge clk);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    #1;
  endtask
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 0;
    in_valid = 0;
    out_ready = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask
  task automatic check_idle(input string name);
    check({name, "_in_ready"}, 0, 32'(in_ready), 1);
    check({name, "_out_valid"}, 0, 32'(out_valid), 0);
    check({name, "_out_last"}, 0, 32'(out_last), 0);
    check({name, "_out_data"}, 0, 32'(out_data), 0);
  endtask
  task automatic expect_beat(input string name, input int idx, input logic [15:0] d, input logic l);
    check({name, "_valid"}, idx, 32'(out_valid), 1);
    check({name, "_data"}, idx, 32'(out_data), 32'(d));
    check({name, "_last"}, idx, 32'(out_last), 32'(l));
  endtask
  task automatic run_stream(input string name, input int nvec, input logic [7:0] base, input bit rnd);
    int pushed = 0;
    int acc = 0;
    int cyc = 0;
    logic [7:0] e;
    while (acc < nvec * 4 && cyc < 300) begin
      e = base + 8'(pushed * 4);
      drive(pushed < nvec * 2, {e + 8'd3, e + 8'd2, e + 8'd1, e}, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (out_valid && out_ready) begin
        e = base + 8'(acc * 2);
        check({name, "_data"}, acc, 32'(out_data), 32'({e + 8'd1, e}));
        check({name, "_last"}, acc, 32'(out_last), 32'(acc % 4 == 3));
        acc++;
      end
      if (in_valid && in_ready) pushed++;
      cyc++;
    end
    check({name, "_beats"}, 0, acc, nvec * 4);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 32'h03020100, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 16'h0100, 1'b0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 16'h0302, 1'b0};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 32'h07060504, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 32'h0b0a0908, 1'b0, 1'b1, 1'b1, 16'h0504, 1'b0};
    tbl[6]  = '{1'b1, 32'h0f0e0d0c, 1'b0, 1'b1, 1'b1, 16'h0504, 1'b0};
    tbl[7]  = '{1'b1, 32'h13121110, 1'b0, 1'b1, 1'b1, 16'h0504, 1'b0};
    tbl[8]  = '{1'b1, 32'h17161514, 1'b0, 1'b0, 1'b1, 16'h0504, 1'b0};
    tbl[9]  = '{1'b1, 32'h17161514, 1'b1, 1'b0, 1'b1, 16'h0504, 1'b0};
    tbl[10] = '{1'b1, 32'h17161514, 1'b1, 1'b0, 1'b1, 16'h0706, 1'b1};
    tbl[11] = '{1'b1, 32'h17161514, 1'b1, 1'b1, 1'b1, 16'h0908, 1'b0};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 16'h0b0a, 1'b0};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 16'h0d0c, 1'b0};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 16'h0f0e, 1'b1};
    tbl[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 16'h1110, 1'b0};
    tbl[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 16'h1312, 1'b0};
    tbl[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 16'h1514, 1'b0};
    tbl[18] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 16'h1716, 1'b1};
    tbl[19] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    do_reset(2);
    check_idle("reset");
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check("tbl_in_ready", i, 32'(in_ready), 32'(tbl[i].e_ir));
      check("tbl_out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
      check("tbl_out_data", i, 32'(out_data), 32'(tbl[i].e_d));
      check("tbl_out_last", i, 32'(out_last), 32'(tbl[i].e_l));
    end
    do_reset(2);
    drive(1, 32'h03020100, 0);
    drive(1, 32'h07060504, 0);
    drive(1, 32'h0b0a0908, 1);
    expect_beat("simul", 0, 16'h0100, 0);
    check("simul_in_ready", 0, 32'(in_ready), 1);
    drive(0, 32'h0, 1);
    expect_beat("simul", 1, 16'h0302, 0);
    drive(0, 32'h0, 1);
    expect_beat("simul", 2, 16'h0504, 0);
    drive(0, 32'h0, 1);
    expect_beat("simul", 3, 16'h0706, 1);
    drive(0, 32'h0, 1);
    expect_beat("simul", 4, 16'h0908, 0);
    drive(0, 32'h0, 1);
    expect_beat("simul", 5, 16'h0b0a, 0);
    drive(0, 32'h0, 1);
    check("simul_empty", 0, 32'(out_valid), 0);
    do_reset(2);
    run_stream("frame", 2, 8'h00, 1'b1);
    do_reset(2);
    drive(1, 32'h03020100, 0);
    drive(1, 32'h07060504, 1);
    expect_beat("pre_rst", 0, 16'h0100, 0);
    do_reset(1);
    check_idle("mid_rst");
    run_stream("post_rst", 1, 8'h20, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
